writeback_buffer: RTL and testbench
===================================

WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of result entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports alu_valid input 1, alu_rd input 5, alu_data input 32, meaning ALU result offer.
REQ-005 SHALL have port alu_ready  output  1  ALU result accepted this cycle when high with alu_valid.
REQ-006 SHALL have ports lsu_valid input 1, lsu_rd input 5, lsu_data input 32, meaning load result offer.
REQ-007 SHALL have port lsu_ready  output  1  load result accepted this cycle when high with lsu_valid.
REQ-008 SHALL have port wb_hold  input  1  suppresses draining while high.
REQ-009 SHALL have ports rf_we output 1, rf_addr output 5, rf_wdata output 32, meaning the integer register file write port.
REQ-010 SHALL have ports count output clog2(DEPTH+1), full output 1, empty output 1, meaning occupancy status.

Function
REQ-011 SHALL be a FIFO of DEPTH entries {rd[4:0], data[31:0]}, with head/tail pointers wrapping modulo DEPTH.
REQ-012 SHALL accept up to two results per cycle and drain at most one per cycle.
REQ-013 SHALL drive alu_ready = (count <= DEPTH-1), independent of wb_hold and of the same-cycle drain.
REQ-014 SHALL drive lsu_ready = (count <= DEPTH-2) | (count == DEPTH-1 & !alu_valid).
REQ-015 SHALL enqueue the ALU result before the LSU result when both are accepted in the same cycle (ALU at tail, LSU at tail+1).
REQ-016 SHALL accept results with rd == 0 (ready per REQ-013/014) but SHALL NOT store them; they consume no slot.
REQ-017 SHALL drive rf_we = !empty & !wb_hold, and rf_addr/rf_wdata from the head entry combinationally; outputs SHALL be zero when rf_we is low.
REQ-018 SHALL pop the head on every cycle rf_we is high.
REQ-019 SHALL have a minimum latency of one cycle: a result accepted in cycle N appears on rf_we no earlier than cycle N+1, and in cycle N+1 if the buffer was empty and wb_hold was low.
REQ-020 SHALL update count(next) = count + pushes - pop, where pushes is the number of stored (rd != 0) accepts in 0..2 and pop is 0..1; count SHALL never exceed DEPTH or go below 0.
REQ-021 SHALL drive full = (count == DEPTH) and empty = (count == 0), both from registered state.
REQ-022 SHALL preserve program order per producer and SHALL deliver two writes to the same rd in enqueue order; no coalescing.
REQ-023 SHALL, when full and draining in the same cycle, still deassert alu_ready (no same-cycle pass-through).
REQ-024 SHALL ignore alu_rd/alu_data when alu_valid is low, and lsu_rd/lsu_data when lsu_valid is low.

Reset
REQ-025 SHALL, while reset_n is low, asynchronously clear head, tail and count, and hold rf_we=0, rf_addr=0, rf_wdata=0, empty=1, full=0.
REQ-026 SHALL discard all buffered entries on reset asserted mid-operation; entry data storage need not be cleared.
REQ-027 SHALL accept new results on the first rising edge after reset_n deasserts.

Structure
REQ-028 SHALL take DEPTH default, the entry field widths (5-bit rd, 32-bit data) and the x0 index from the shared register-defines package.
REQ-029 SHALL be a single module; the entry storage MAY be a sub-module wb_fifo_ram (DEPTH x 37, two write ports, one async read port).

Verification
REQ-030 Scenario: empty, alu_valid, rd=5, data=0xDEADBEEF at cycle 0 -> rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF at cycle 1; empty=1 at cycle 2.
REQ-031 Scenario: ALU rd=3/0x11 and LSU rd=3/0x22 in the same cycle -> writes rd3=0x11, then rd3=0x22 on consecutive cycles.
REQ-032 Scenario: wb_hold=1, push 4 ALU results -> full=1, alu_ready=0, count=4; release hold -> four writes in order, then empty=1.
REQ-033 Scenario: count=3, both valid -> alu_ready=1, lsu_ready=0; count=3 with lsu_valid only -> lsu_ready=1.
REQ-034 Scenario: alu rd=0, data=0x55 accepted -> count unchanged, no rf_we.
REQ-035 Scenario: count=2, reset_n low mid-cycle -> rf_we drops immediately, count=0, no stale write after release.

Source files
------------

// File: rtl/writeback_buffer_pkg.sv
// Shared register-defines package for the writeback buffer.
// Holds the default buffer depth, the entry field widths, the x0 register
// index and the packed entry type used by the buffer and its storage.
package writeback_buffer_pkg;

   localparam int unsigned WbDepthDefault = 4;
   localparam int unsigned RdWidth        = 5;
   localparam int unsigned DataWidth      = 32;
   localparam int unsigned EntryWidth     = RdWidth + DataWidth;
   localparam logic [RdWidth-1:0] RegX0   = '0;

   typedef struct packed {
      logic [RdWidth-1:0]   rd;
      logic [DataWidth-1:0] data;
   } wb_entry_t;

   function automatic wb_entry_t pack_entry(logic [RdWidth-1:0] rd, logic [DataWidth-1:0] data);
      wb_entry_t e;
      e.rd   = rd;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/wb_fifo_ram.sv
// Entry storage for the writeback buffer: DEPTH x WIDTH register array with
// two synchronous write ports and one asynchronous read port. Contents are
// not reset. The two write addresses are distinct whenever both enables are
// high.
// Ports:
//   clk                          clock
//   we_a, addr_a, wdata_a        write port A
//   we_b, addr_b, wdata_b        write port B
//   raddr, rdata                 combinational read port
module wb_fifo_ram #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 37
) (
   input  logic                     clk,
   input  logic                     we_a,
   input  logic [$clog2(DEPTH)-1:0] addr_a,
   input  logic [WIDTH-1:0]         wdata_a,
   input  logic                     we_b,
   input  logic [$clog2(DEPTH)-1:0] addr_b,
   input  logic [WIDTH-1:0]         wdata_b,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
      if (we_b) mem[addr_b] <= wdata_b;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer: merges ALU and load results into one register-file write
// port. Up to two results are accepted per cycle (ALU first, then LSU) and at
// most one is drained per cycle. Results targeting x0 are accepted but dropped.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   alu_valid/alu_rd/alu_data/alu_ready  ALU result offer and accept
//   lsu_valid/lsu_rd/lsu_data/lsu_ready  load result offer and accept
//   wb_hold                              stalls draining
//   rf_we/rf_addr/rf_wdata               register file write port
//   count/full/empty                     occupancy status
module writeback_buffer
   import writeback_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = WbDepthDefault
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       alu_valid,
   input  logic [RdWidth-1:0]         alu_rd,
   input  logic [DataWidth-1:0]       alu_data,
   output logic                       alu_ready,
   input  logic                       lsu_valid,
   input  logic [RdWidth-1:0]         lsu_rd,
   input  logic [DataWidth-1:0]       lsu_data,
   output logic                       lsu_ready,
   input  logic                       wb_hold,
   output logic                       rf_we,
   output logic [RdWidth-1:0]         rf_addr,
   output logic [DataWidth-1:0]       rf_wdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [PtrW-1:0] head_q, tail_q;
   logic [CntW-1:0] count_q;
   logic            alu_push, lsu_push, pop;
   logic [PtrW-1:0] lsu_addr;
   wb_entry_t       head_entry;
   logic [EntryWidth-1:0] rd_raw;

   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(DEPTH));
   assign count = count_q;

   // Readiness looks only at registered occupancy, never at the same-cycle pop,
   // so a full buffer refuses new results even while draining.
   assign alu_ready = (count_q <= CntW'(DEPTH - 1));
   assign lsu_ready = (count_q <= CntW'(DEPTH - 2)) ||
                      ((count_q == CntW'(DEPTH - 1)) && !alu_valid);

   assign alu_push = alu_valid && alu_ready && (alu_rd != RegX0);
   assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != RegX0);
   assign pop      = !empty && !wb_hold;

   // LSU lands right behind the ALU entry when both are stored this cycle.
   assign lsu_addr = tail_q + PtrW'(alu_push);

   wb_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EntryWidth)
   ) u_ram (
      .clk     (clk),
      .we_a    (alu_push),
      .addr_a  (tail_q),
      .wdata_a (pack_entry(alu_rd, alu_data)),
      .we_b    (lsu_push),
      .addr_b  (lsu_addr),
      .wdata_b (pack_entry(lsu_rd, lsu_data)),
      .raddr   (head_q),
      .rdata   (rd_raw)
   );

   assign head_entry = wb_entry_t'(rd_raw);
   assign rf_we      = pop;
   assign rf_addr    = pop ? head_entry.rd   : '0;
   assign rf_wdata   = pop ? head_entry.data : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PtrW'(pop);
         tail_q  <= tail_q + PtrW'(alu_push) + PtrW'(lsu_push);
         count_q <= count_q + CntW'(alu_push) + CntW'(lsu_push) - CntW'(pop);
      end
   end

endmodule

// File: tb/tb_writeback_buffer.sv
module tb_writeback_buffer;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset_n;
   logic        alu_valid, lsu_valid, wb_hold;
   logic [4:0]  alu_rd, lsu_rd;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, lsu_ready, rf_we, full, empty;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic [2:0]  count;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: ordered list of stored {rd, data} entries.
   logic [36:0] q[$];

   writeback_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .lsu_valid (lsu_valid),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .lsu_ready (lsu_ready),
      .wb_hold   (wb_hold),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_wdata  (rf_wdata),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Per-cycle comparison against the model, then advance the model to the
   // state it must hold after the coming rising edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         q.delete();
         check("rst_rf_we", 64'(rf_we), 64'd0);
         check("rst_empty", 64'(empty), 64'd1);
         check("rst_full",  64'(full),  64'd0);
         check("rst_count", 64'(count), 64'd0);
      end else begin
         automatic int  sz   = q.size();
         automatic bit  e_we = (sz > 0) && !wb_hold;
         automatic bit  e_ar = (sz <= DEPTH - 1);
         automatic bit  e_lr = (sz <= DEPTH - 2) || ((sz == DEPTH - 1) && !alu_valid);
         automatic logic [4:0]  e_addr = e_we ? q[0][36:32] : 5'd0;
         automatic logic [31:0] e_data = e_we ? q[0][31:0]  : 32'd0;
         check("m_rf_we",     64'(rf_we),     64'(e_we));
         check("m_rf_addr",   64'(rf_addr),   64'(e_addr));
         check("m_rf_wdata",  64'(rf_wdata),  64'(e_data));
         check("m_count",     64'(count),     64'(sz));
         check("m_full",      64'(full),      64'(sz == DEPTH));
         check("m_empty",     64'(empty),     64'(sz == 0));
         check("m_alu_ready", 64'(alu_ready), 64'(e_ar));
         check("m_lsu_ready", 64'(lsu_ready), 64'(e_lr));
         if (e_we) void'(q.pop_front());
         if (alu_valid && e_ar && alu_rd != 5'd0) q.push_back({alu_rd, alu_data});
         if (lsu_valid && e_lr && lsu_rd != 5'd0) q.push_back({lsu_rd, lsu_data});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; lsu_valid = 0;
      alu_rd = 0; alu_data = 0; lsu_rd = 0; lsu_data = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 0; wb_hold = 0;
      idle();
      step(); step();
      check("reset_empty", 64'(empty), 64'd1);
      check("reset_rf_we", 64'(rf_we), 64'd0);
      reset_n = 1;

      // Single ALU result, one-cycle latency.
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      check("s1_alu_ready", 64'(alu_ready), 64'd1);
      step(); idle();
      check("s1_rf_we",    64'(rf_we),    64'd1);
      check("s1_rf_addr",  64'(rf_addr),  64'd5);
      check("s1_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
      step();
      check("s1_empty", 64'(empty), 64'd1);

      // Same rd from both producers: ALU first.
      alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
      lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h22;
      step(); idle();
      check("s2_first",  64'(rf_wdata), 64'h11);
      check("s2_count",  64'(count),    64'd2);
      step();
      check("s2_second", 64'(rf_wdata), 64'h22);
      check("s2_addr",   64'(rf_addr),  64'd3);
      step();

      // Fill under hold, then drain while full with a refused ALU offer.
      wb_hold = 1;
      for (int i = 1; i <= 4; i++) begin
         alu_valid = 1; alu_rd = 5'(i); alu_data = 32'hA0 + 32'(i);
         step();
      end
      idle();
      check("s3_full",      64'(full),      64'd1);
      check("s3_count",     64'(count),     64'd4);
      check("s3_alu_ready", 64'(alu_ready), 64'd0);
      wb_hold = 0; alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
      #1;
      check("s3_drain_ready", 64'(alu_ready), 64'd0);
      check("s3_w1", 64'(rf_addr), 64'd1);
      step(); idle();
      check("s3_w2", 64'(rf_wdata), 64'hA2);
      step();
      check("s3_w3", 64'(rf_wdata), 64'hA3);
      step();
      check("s3_w4", 64'(rf_wdata), 64'hA4);
      step();
      check("s3_empty", 64'(empty), 64'd1);

      // Count 3: LSU readiness depends on ALU offer.
      wb_hold = 1;
      for (int i = 6; i <= 8; i++) begin
         alu_valid = 1; alu_rd = 5'(i); alu_data = 32'(i);
         step();
      end
      alu_valid = 1; alu_rd = 10; lsu_valid = 1; lsu_rd = 11;
      #1;
      check("s4_alu_ready", 64'(alu_ready), 64'd1);
      check("s4_lsu_ready", 64'(lsu_ready), 64'd0);
      alu_valid = 0;
      #1;
      check("s4_lsu_only", 64'(lsu_ready), 64'd1);
      idle();
      wb_hold = 0;
      repeat (4) step();

      // x0 results consume no slot.
      alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
      step(); idle();
      check("s5_count", 64'(count), 64'd0);
      check("s5_rf_we", 64'(rf_we), 64'd0);

      // Reset in the middle of a cycle with entries pending.
      wb_hold = 1;
      alu_valid = 1; alu_rd = 12; alu_data = 32'hC;
      lsu_valid = 1; lsu_rd = 13; lsu_data = 32'hD;
      step(); idle();
      check("s6_count", 64'(count), 64'd2);
      wb_hold = 0;
      #1;
      check("s6_we_before", 64'(rf_we), 64'd1);
      #1 reset_n = 0;
      #1;
      check("s6_we_rst",    64'(rf_we), 64'd0);
      check("s6_count_rst", 64'(count), 64'd0);
      step();
      reset_n = 1;
      check("s6_no_stale", 64'(rf_we), 64'd0);
      alu_valid = 1; alu_rd = 14; alu_data = 32'hE;
      step(); idle();
      check("s6_first_accept", 64'(rf_addr), 64'd14);
      step();

      // Mixed traffic checked by the model.
      for (int i = 0; i < 80; i++) begin
         alu_valid = 1'($urandom_range(0, 1));
         alu_rd    = 5'($urandom_range(0, 3));
         alu_data  = $urandom;
         lsu_valid = 1'($urandom_range(0, 1));
         lsu_rd    = 5'($urandom_range(0, 3));
         lsu_data  = $urandom;
         wb_hold   = ($urandom_range(0, 3) == 0);
         step();
      end
      idle();
      wb_hold = 0;
      repeat (6) step();
      check("final_empty", 64'(empty), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
